// File: rtl/tmr_scrub_writer.sv
// -----------------------------------------------------------------------------
// tmr_scrub_writer
//
// Write side of a triple-redundant storage path. An accepted word is written
// into three copies (A/B/C). The copies are then compared. If any bit
// disagrees, all three copies are rewritten with the bitwise majority vote.
// While idle, a periodic scrub repeats the same check. The fault-injection
// port flips chosen bits in one copy so that the repair path can be exercised.
//
// Parameters
//   WIDTH         data word width (>=1)
//   CNT_W         repair counter width (>=1), saturates at all-ones
//   SCRUB_PERIOD  idle cycles between scrub checks, 0 disables scrubbing
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   wr_valid/wr_ready      write handshake, wr_data sampled on accept
//   inj_en/inj_sel/inj_mask  flip inj_mask bits in copy inj_sel (3 = none)
//   copy_a/b/c             the three stored copies (registers)
//   voted_data             combinational bitwise majority of the copies
//   mismatch, multi_err    registered, high during the REPAIR cycle
//   repair_cnt             saturating count of repairs
//   busy                   ~wr_ready
// -----------------------------------------------------------------------------
module tmr_scrub_writer #(
   parameter int WIDTH        = 8,
   parameter int CNT_W        = 8,
   parameter int SCRUB_PERIOD = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             inj_en,
   input  logic [1:0]       inj_sel,
   input  logic [WIDTH-1:0] inj_mask,
   output logic [WIDTH-1:0] copy_a,
   output logic [WIDTH-1:0] copy_b,
   output logic [WIDTH-1:0] copy_c,
   output logic [WIDTH-1:0] voted_data,
   output logic             mismatch,
   output logic             multi_err,
   output logic [CNT_W-1:0] repair_cnt,
   output logic             busy
);

   localparam int TMR_W = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST =
      TMR_W'((SCRUB_PERIOD > 0) ? SCRUB_PERIOD - 1 : 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      REPAIR = 2'd2
   } state_t;

   state_t           state;
   logic [TMR_W-1:0] timer;
   logic [WIDTH-1:0] nxt_a, nxt_b, nxt_c;
   logic             dis;
   logic [1:0]       n_diff;
   logic             multi;

   assign voted_data = (copy_a & copy_b) | (copy_b & copy_c) | (copy_a & copy_c);
   assign busy       = ~wr_ready;

   // Any disagreement anywhere in the word triggers a repair.
   assign dis = !((copy_a == copy_b) && (copy_b == copy_c));

   // Count how many copies differ from the vote. Two or more means the
   // errors landed in different copies.
   assign n_diff = 2'(copy_a != voted_data) + 2'(copy_b != voted_data)
                 + 2'(copy_c != voted_data);
   assign multi  = (n_diff >= 2'd2);

   // Next value of each copy. Injection is applied on top of whatever the
   // copy would take at this edge, including the REPAIR rewrite.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      nxt_a = copy_a;
      nxt_b = copy_b;
      nxt_c = copy_c;
      if (state == IDLE && wr_valid) begin
         nxt_a = wr_data;
         nxt_b = wr_data;
         nxt_c = wr_data;
      end else if (state == REPAIR) begin
         nxt_a = voted_data;
         nxt_b = voted_data;
         nxt_c = voted_data;
      end
      if (inj_en) begin
         case (inj_sel)
            2'd0:    nxt_a = nxt_a ^ inj_mask;
            2'd1:    nxt_b = nxt_b ^ inj_mask;
            2'd2:    nxt_c = nxt_c ^ inj_mask;
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the copies are plain registers, not a memory array, so they are reset like any other state.
         copy_a     <= '0;
         copy_b     <= '0;
         copy_c     <= '0;
         state      <= IDLE;
         wr_ready   <= 1'b1;
         mismatch   <= 1'b0;
         multi_err  <= 1'b0;
         repair_cnt <= '0;
         timer      <= '0;
      end else begin
         copy_a <= nxt_a;
         copy_b <= nxt_b;
         copy_c <= nxt_c;
         case (state)
            IDLE: begin
               if (wr_valid) begin
                  timer    <= '0;
                  state    <= CHECK;
                  wr_ready <= 1'b0;
               end else if (SCRUB_PERIOD != 0 && timer == TMR_LAST) begin
                  timer    <= '0;
                  state    <= CHECK;
                  wr_ready <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            CHECK: begin
               mismatch  <= dis;
               multi_err <= dis && multi;
               if (dis) begin
                  state <= REPAIR;
               end else begin
                  state    <= IDLE;
                  wr_ready <= 1'b1;
               end
            end
            REPAIR: begin
               if (repair_cnt != '1) repair_cnt <= repair_cnt + 1'b1;
               mismatch  <= 1'b0;
               multi_err <= 1'b0;
               state     <= IDLE;
               wr_ready  <= 1'b1;
            end
            default: begin
               state    <= IDLE;
               wr_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
